sm_hex_scan_display: RTL

Parametrised time-multiplexed hex display driver for boards with a shared segment bus and per-digit common lines. It succeeds the one-decoder-per-digit scheme. It scans DIGITS nibbles of a debug word (e.g. CPU regData) onto one 7-segment bus and adds:
- programmable scan rate
- tear-free frame snapshot
- leading-zero blanking
- per-digit enable and decimal points
- ghosting dead-time

---
 rtl/sm_hex_scan_display.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sm_hex_scan_display.sv
// Time-multiplexed hex display driver: scans DIGITS nibbles of a snapshotted
// debug word onto one 7-segment bus, with dead-time between digit slots.
module sm_hex_scan_display #(
    parameter int DIGITS         = 8,
    parameter int PRESCALE_W     = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS*4-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  blank_lz,
    input  logic                  freeze,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame_done
);

    localparam int               IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [6:0]       SEG_OFF   = {7{SEG_ACTIVE_LOW}};
    localparam logic             SEGDP_OFF = SEG_ACTIVE_LOW;
    localparam logic [DIGITS-1:0] DIG_OFF  = {DIGITS{DIG_ACTIVE_LOW}};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    function automatic logic [6:0] seg_level(input logic [6:0] on);
        return SEG_ACTIVE_LOW ? ~on : on;
    endfunction

    function automatic logic [DIGITS-1:0] dig_level(input logic [DIGITS-1:0] on);
        return DIG_ACTIVE_LOW ? ~on : on;
    endfunction

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIGITS*4-1:0]   shadow_q, shadow_d;
    logic [DIGITS-1:0]     dps_q, dps_d;
    logic                  dead_q, dead_d;
    logic                  started_q, started_d;
    logic                  frame_done_q, frame_done_d;
    logic [6:0]            seg_q, seg_d;
    logic                  seg_dp_q, seg_dp_d;
    logic [DIGITS-1:0]     dig_q, dig_d;

    logic                  tick, wrap, zero_above, lit;
    logic [DIGITS-1:0]     lz, onehot;
    logic [3:0]            nib;

    assign tick = (cnt_q == prescale);
    assign wrap = (idx_q == LAST_IDX);

    // An over-range count simply runs up through all-ones and wraps to meet prescale.
    always_comb begin
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        dps_d        = dps_q;
        started_d    = started_q | tick;
        dead_d       = tick;
        frame_done_d = tick & wrap;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
            if ((wrap || !started_q) && !freeze) begin
                shadow_d = data;
                dps_d    = dp;
            end
        end
    end

    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (shadow_q[i*4 +: 4] == 4'h0);
            lz[i]      = blank_lz && zero_above;
        end
    end

    // Nothing is lit until the first tick has loaded the snapshot.
    always_comb begin
        nib         = shadow_q[4*idx_q +: 4];
        lit         = digit_en[idx_q] && !lz[idx_q];
        onehot      = '0;
        onehot[idx_q] = 1'b1;
        seg_d       = SEG_OFF;
        seg_dp_d    = SEGDP_OFF;
        dig_d       = DIG_OFF;
        if (!dead_q && started_q) begin
            dig_d = dig_level(onehot);
            if (lit) begin
                seg_d = seg_level(hex_to_seg(nib));
                if (dps_q[idx_q]) seg_dp_d = ~SEGDP_OFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            dps_q        <= '0;
            dead_q       <= 1'b0;
            started_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            seg_dp_q     <= SEGDP_OFF;
            dig_q        <= DIG_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            dps_q        <= dps_d;
            dead_q       <= dead_d;
            started_q    <= started_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            dig_q        <= dig_d;
        end
    end

    assign seg        = seg_q;
    assign seg_dp     = seg_dp_q;
    assign dig        = dig_q;
    assign frame_done = frame_done_q;

endmodule
